// File: rtl/sa_operand_feeder_if.sv
// sa_operand_feeder_if
//   Bundles the feeder's control handshake, operand buffer read ports and
//   systolic array connections.
//   master : feeder side (drives read enables/addresses, array operands,
//            busy/done/result; receives start/config, buffer data, out_c)
//   slave  : environment side (tile controller, operand buffers, array)
//   Optional macro SA_FEEDER_PERF_CNT_EN adds cycle_cnt/job_cnt.
interface sa_operand_feeder_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic [ADDR_W-1:0] k_len;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic              busy;
    logic              done;
    logic              a_rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_data;
    logic              b_rd_en;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       b_data;
    logic              sa_rst_n;
    logic [31:0]       sa_in_a;
    logic [31:0]       sa_in_b;
    logic [127:0]      sa_out_c;
    logic [63:0]       result;
`ifdef SA_FEEDER_PERF_CNT_EN
    logic [31:0]       cycle_cnt;
    logic [15:0]       job_cnt;

    modport master (
        input  start, k_len, a_base, b_base, a_data, b_data, sa_out_c,
        output busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               sa_rst_n, sa_in_a, sa_in_b, result, cycle_cnt, job_cnt
    );
    modport slave (
        output start, k_len, a_base, b_base, a_data, b_data, sa_out_c,
        input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               sa_rst_n, sa_in_a, sa_in_b, result, cycle_cnt, job_cnt
    );
`else
    modport master (
        input  start, k_len, a_base, b_base, a_data, b_data, sa_out_c,
        output busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               sa_rst_n, sa_in_a, sa_in_b, result
    );
    modport slave (
        output start, k_len, a_base, b_base, a_data, b_data, sa_out_c,
        input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               sa_rst_n, sa_in_a, sa_in_b, result
    );
`endif
endinterface

// File: rtl/sa_operand_feeder.sv
// sa_operand_feeder
//   Initiator for a 4x4 int8 systolic array. Streams k_len A/B words from
//   synchronous operand buffers, applies the diagonal skew (lane j delayed
//   j cycles), clears the array at job start, drains the pipeline and
//   captures result row 0 from sa_out_c[127:64].
//   Ports: clk, rst_n (async active-low), bus (sa_operand_feeder_if.master).
//   Optional macro SA_FEEDER_PERF_CNT_EN: saturating busy-cycle and job
//   counters (cycle_cnt, job_cnt).
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start
//   FEED  | issuing k_len buffer reads, array clear on first cycle
//   DRAIN | skew flush plus DRAIN_CYCLES zero-feed cycles
//   DONE  | one-cycle done pulse, result captured at end of cycle
module sa_operand_feeder #(
    parameter int ADDR_W       = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sa_operand_feeder_if.master    bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DRAIN_LEN = 5 + DRAIN_CYCLES;
    localparam int DRN_W     = $clog2(DRAIN_LEN + 1);
    localparam int CNT_W     = (ADDR_W > DRN_W) ? ADDR_W : DRN_W;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              job_nz;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic              sa_rst_n;
    logic [63:0]       result;

    // Skew pipeline: s0 holds the word read one cycle earlier (zero when no
    // read was issued), deeper lanes are delayed by extra byte registers.
    logic              a_vld, b_vld;
    logic [31:0]       a_s0, b_s0;
    logic [7:0]        a_l1, b_l1;
    logic [1:0][7:0]   a_l2, b_l2;
    logic [2:0][7:0]   a_l3, b_l3;

    logic              busy, done;
    logic              unused_out_c;

    assign busy = (state == S_FEED) || (state == S_DRAIN);
    assign done = (state == S_DONE);
    assign unused_out_c = ^bus.sa_out_c[63:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            job_nz   <= 1'b0;
            a_rd_en  <= 1'b0;
            b_rd_en  <= 1'b0;
            a_addr   <= '0;
            b_addr   <= '0;
            sa_rst_n <= 1'b0;
            result   <= '0;
        end else begin
            sa_rst_n <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.k_len != '0) begin
                            state    <= S_FEED;
                            cnt      <= CNT_W'(bus.k_len) - CNT_W'(1);
                            job_nz   <= 1'b1;
                            a_rd_en  <= 1'b1;
                            b_rd_en  <= 1'b1;
                            a_addr   <= bus.a_base;
                            b_addr   <= bus.b_base;
                            sa_rst_n <= 1'b0;
                        end else begin
                            state  <= S_DONE;
                            job_nz <= 1'b0;
                        end
                    end
                end
                S_FEED: begin
                    if (cnt == '0) begin
                        state   <= S_DRAIN;
                        cnt     <= CNT_W'(DRAIN_LEN - 1);
                        a_rd_en <= 1'b0;
                        b_rd_en <= 1'b0;
                    end else begin
                        cnt    <= cnt - CNT_W'(1);
                        a_addr <= a_addr + ADDR_W'(1);
                        b_addr <= b_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    // zero-length jobs never touched the array, keep old result
                    if (job_nz) begin
                        result <= bus.sa_out_c[127:64];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld <= 1'b0;
            b_vld <= 1'b0;
            a_s0  <= '0;
            b_s0  <= '0;
            a_l1  <= '0;
            b_l1  <= '0;
            a_l2  <= '0;
            b_l2  <= '0;
            a_l3  <= '0;
            b_l3  <= '0;
        end else begin
            a_vld <= a_rd_en;
            b_vld <= b_rd_en;
            a_s0  <= a_vld ? bus.a_data : 32'h0;
            b_s0  <= b_vld ? bus.b_data : 32'h0;
            a_l1  <= a_s0[23:16];
            b_l1  <= b_s0[23:16];
            a_l2  <= {a_l2[0], a_s0[15:8]};
            b_l2  <= {b_l2[0], b_s0[15:8]};
            a_l3  <= {a_l3[1:0], a_s0[7:0]};
            b_l3  <= {b_l3[1:0], b_s0[7:0]};
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.a_rd_en  = a_rd_en;
    assign bus.b_rd_en  = b_rd_en;
    assign bus.a_addr   = a_addr;
    assign bus.b_addr   = b_addr;
    assign bus.sa_rst_n = sa_rst_n;
    assign bus.sa_in_a  = {a_s0[31:24], a_l1, a_l2[1], a_l3[2]};
    assign bus.sa_in_b  = {b_s0[31:24], b_l1, b_l2[1], b_l3[2]};
    assign bus.result   = result;

`ifdef SA_FEEDER_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [15:0] job_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            job_cnt   <= '0;
        end else begin
            if (busy && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (done && (job_cnt != '1)) begin
                job_cnt <= job_cnt + 16'd1;
            end
        end
    end

    assign bus.cycle_cnt = cycle_cnt;
    assign bus.job_cnt   = job_cnt;
`endif

endmodule

// File: tb/tb_sa_operand_feeder.sv
module tb_sa_operand_feeder;
    localparam int ADDR_W = 8;
    localparam int DC     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_operand_feeder_if #(.ADDR_W(ADDR_W)) bus();

    sa_operand_feeder #(.ADDR_W(ADDR_W), .DRAIN_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // operand buffers, 1-cycle read latency
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    always_ff @(posedge clk) begin
        if (bus.a_rd_en) bus.a_data <= mem_a[bus.a_addr];
        if (bus.b_rd_en) bus.b_data <= mem_b[bus.b_addr];
    end

    // behavioural 4x4 array: in_a lane j flows down column j, in_b lane i
    // flows right along row i, each PE accumulates a*b
    logic signed [7:0]  pa [4][4];
    logic signed [7:0]  pb [4][4];
    logic signed [15:0] pc [4][4];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!bus.sa_rst_n) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                    pc[i][j] <= '0;
                end else begin
                    if (i == 0) pa[i][j] <= $signed(bus.sa_in_a[31-8*j -: 8]);
                    else        pa[i][j] <= pa[(i>0)?i-1:0][j];
                    if (j == 0) pb[i][j] <= $signed(bus.sa_in_b[31-8*i -: 8]);
                    else        pb[i][j] <= pb[i][(j>0)?j-1:0];
                    pc[i][j] <= pc[i][j] + pa[i][j] * pb[i][j];
                end
            end
        end
    end
    assign bus.sa_out_c = {pc[0][0], pc[0][1], pc[0][2], pc[0][3],
                           pc[1][0], pc[1][1], pc[1][2], pc[1][3]};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [31:0] tr_a [64];
    logic [31:0] tr_b [64];
    logic        tr_rst [64];
    logic        tr_rd [64];
    logic        tr_busy [64];
    logic [7:0]  tr_addr [64];
    logic [7:0]  tr_baddr [64];

    task automatic fill(input logic [31:0] aw, input logic [31:0] bw);
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = aw;
            mem_b[i] = bw;
        end
    endtask

    // Starts a job and traces cycles c=0.. until done. poke_c>=0 asserts
    // start (k_len=2) at cycles poke_c and poke_c+6 while the job runs.
    task automatic run_job(input int k, input logic [7:0] ab, input logic [7:0] bb,
                           input int poke_c, output int done_c);
        logic [31:0] kv;
        kv = k;
        for (int i = 0; i < 64; i++) begin
            tr_a[i] = '0; tr_b[i] = '0; tr_rst[i] = 1'b1; tr_rd[i] = 1'b0;
            tr_busy[i] = 1'b0; tr_addr[i] = '0; tr_baddr[i] = '0;
        end
        @(negedge clk);
        bus.start = 1'b1; bus.k_len = kv[7:0]; bus.a_base = ab; bus.b_base = bb;
        @(negedge clk);
        bus.start = 1'b0;
        done_c = -1;
        for (int c = 0; c < 64; c++) begin
            tr_a[c] = bus.sa_in_a;   tr_b[c] = bus.sa_in_b;
            tr_rst[c] = bus.sa_rst_n; tr_rd[c] = bus.a_rd_en & bus.b_rd_en;
            tr_busy[c] = bus.busy;   tr_addr[c] = bus.a_addr; tr_baddr[c] = bus.b_addr;
            if (bus.done) begin
                done_c = c;
                break;
            end
            @(negedge clk);
            if (poke_c >= 0 && (c + 1 == poke_c || c + 1 == poke_c + 6)) begin
                bus.start = 1'b1; bus.k_len = 8'd2;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        if (done_c < 0) begin
            n_chk++; n_fail++;
            $display("FAIL job_timeout: no done within 64 cycles, k_len=%0d", k);
        end
    endtask

    typedef struct {
        int          k;
        logic [7:0]  ab;
        logic [7:0]  bb;
        logic [31:0] aw;
        logic [31:0] bw;
        int          exp_done;
        int          exp_last;
        logic [63:0] exp_res;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int dc_o, last, nrd, nlow, nbusy, ndone;
        logic [7:0] eb;
        logic [31:0] exp_a;

        vecs[0] = '{4, 8'h00, 8'h10, 32'h01020304, 32'h01010101, 13, 8,
                    {16'd4, 16'd8, 16'd12, 16'd16}};
        vecs[1] = '{1, 8'h20, 8'h30, 32'h01020304, 32'h02020202, 10, 5,
                    {16'd2, 16'd4, 16'd6, 16'd8}};
        vecs[2] = '{8, 8'hF0, 8'h40, 32'h01020304, 32'h03030303, 17, 12,
                    {16'd24, 16'd48, 16'd72, 16'd96}};

        bus.start = 1'b0; bus.k_len = '0; bus.a_base = '0; bus.b_base = '0;
        fill(32'h0, 32'h0);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",     {63'b0, bus.busy},     64'd0);
        chk("rst_done",     {63'b0, bus.done},     64'd0);
        chk("rst_rd_en",    {62'b0, bus.a_rd_en, bus.b_rd_en}, 64'd0);
        chk("rst_addr",     {48'b0, bus.a_addr, bus.b_addr},   64'd0);
        chk("rst_sa_in",    {bus.sa_in_a, bus.sa_in_b},        64'd0);
        chk("rst_sa_rst_n", {63'b0, bus.sa_rst_n}, 64'd0);
        chk("rst_result",   bus.result,            64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sa_rst_n_release", {63'b0, bus.sa_rst_n}, 64'd1);

        // table-driven jobs
        foreach (vecs[v]) begin
            fill(vecs[v].aw, vecs[v].bw);
            run_job(vecs[v].k, vecs[v].ab, vecs[v].bb, -1, dc_o);
            last = -1; nrd = 0; nlow = 0; nbusy = 0;
            for (int c = 0; c < 64; c++) begin
                if (tr_a[c] != 0 || tr_b[c] != 0) last = c;
                if (tr_rd[c]) nrd++;
                if (!tr_rst[c]) nlow++;
                if (tr_busy[c]) nbusy++;
            end
            chk($sformatf("v%0d_done_c", v),   dc_o,  vecs[v].exp_done);
            chk($sformatf("v%0d_last_nz", v),  last,  vecs[v].exp_last);
            chk($sformatf("v%0d_rd_cnt", v),   nrd,   vecs[v].k);
            chk($sformatf("v%0d_busy_cnt", v), nbusy, vecs[v].exp_done);
            chk($sformatf("v%0d_clr_c0", v),   {63'b0, tr_rst[0]}, 64'd0);
            chk($sformatf("v%0d_clr_cnt", v),  nlow,  1);
            chk($sformatf("v%0d_in_a_c2", v),  tr_a[2], {vecs[v].aw[31:24], 24'h0});
            chk($sformatf("v%0d_in_b_c2", v),  tr_b[2], {vecs[v].bw[31:24], 24'h0});
            chk($sformatf("v%0d_in_a_last", v), tr_a[vecs[v].k + 4], {24'h0, vecs[v].aw[7:0]});
            chk($sformatf("v%0d_a_addr0", v),  tr_addr[0], vecs[v].ab);
            eb = vecs[v].bb + 8'(vecs[v].k - 1);
            chk($sformatf("v%0d_b_addr_last", v), tr_baddr[vecs[v].k - 1], eb);
            @(negedge clk);
            chk($sformatf("v%0d_result", v), bus.result, vecs[v].exp_res);
        end

        // zero length: immediate done, no reads, no clear, result kept
        run_job(0, 8'h00, 8'h00, -1, dc_o);
        chk("zero_done_c",  dc_o, 0);
        chk("zero_rd",      {63'b0, tr_rd[0]},  64'd0);
        chk("zero_sa_rst",  {63'b0, tr_rst[0]}, 64'd1);
        chk("zero_busy",    {63'b0, tr_busy[0]}, 64'd0);
        @(negedge clk);
        chk("zero_result_kept", bus.result, vecs[2].exp_res);

        // skew: single word AABBCCDD spreads diagonally
        fill(32'hAABBCCDD, 32'h0);
        run_job(1, 8'h00, 8'h00, -1, dc_o);
        chk("skew_done_c", dc_o, 10);
        for (int c = 0; c <= 10; c++) begin
            case (c)
                2:       exp_a = 32'hAA000000;
                3:       exp_a = 32'h00BB0000;
                4:       exp_a = 32'h0000CC00;
                5:       exp_a = 32'h000000DD;
                default: exp_a = 32'h0;
            endcase
            chk($sformatf("skew_c%0d", c), tr_a[c], exp_a);
        end
        @(negedge clk);

        // address wrap
        fill(32'h01020304, 32'h01010101);
        run_job(4, 8'hFE, 8'h00, -1, dc_o);
        nrd = 0;
        for (int c = 0; c < 64; c++) if (tr_rd[c]) nrd++;
        chk("wrap_rd_cnt", nrd, 4);
        chk("wrap_addr", {32'b0, tr_addr[0], tr_addr[1], tr_addr[2], tr_addr[3]}, 64'hFEFF0001);
        chk("wrap_rd_off", {63'b0, tr_rd[4]}, 64'd0);
        @(negedge clk);

        // start pulses while busy are ignored
        run_job(4, 8'h00, 8'h10, 3, dc_o);
        chk("busy_done_c", dc_o, 13);
        ndone = 0; nbusy = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (bus.busy) nbusy++;
        end
        chk("busy_extra_done", ndone, 0);
        chk("busy_extra_busy", nbusy, 0);

        // reset in the middle of a k_len=8 job
        @(negedge clk);
        bus.start = 1'b1; bus.k_len = 8'd8; bus.a_base = 8'h00; bus.b_base = 8'h10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_pre_in_a", bus.sa_in_a, 32'h01020000);
        rst_n = 1'b0;
        #1;
        chk("mid_busy",     {63'b0, bus.busy},    64'd0);
        chk("mid_rd_en",    {62'b0, bus.a_rd_en, bus.b_rd_en}, 64'd0);
        chk("mid_addr",     {48'b0, bus.a_addr, bus.b_addr},   64'd0);
        chk("mid_sa_in",    {bus.sa_in_a, bus.sa_in_b},        64'd0);
        chk("mid_sa_rst_n", {63'b0, bus.sa_rst_n}, 64'd0);
        chk("mid_result",   bus.result, 64'd0);
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mid_no_done", ndone, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // two back-to-back jobs after release
        run_job(4, 8'h00, 8'h10, -1, dc_o);
        chk("post_done_c1", dc_o, 13);
        run_job(4, 8'h00, 8'h10, -1, dc_o);
        chk("post_done_c2", dc_o, 13);
        @(negedge clk);
        chk("post_result", bus.result, {16'd4, 16'd8, 16'd12, 16'd16});
`ifdef SA_FEEDER_PERF_CNT_EN
        chk("perf_cycle_cnt", bus.cycle_cnt, 64'd26);
        chk("perf_job_cnt",   bus.job_cnt,   64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
